bedpbram_tdp: RTL
=================

Name: bedpbram_tdp

Overview:
Parametrised true-dual-port RAM with byte (column) enables on both ports; successor to the single-write-port byte-enabled RAM.
- Column count, same-port read-during-write mode and an optional output pipeline register are all parameters.
- Includes deterministic write-collision arbitration and a post-reset memory-clear engine.
- Sits between the CPU data port (port A) and a DMA/UART/video side (port B).

Parameters:
- ADDRESS_BITWIDTH, 16, word address width; depth = 2**ADDRESS_BITWIDTH.
- DATA_BITWIDTH, 32, word width; must be a multiple of DATA_COLUMN_BITWIDTH.
- DATA_COLUMN_BITWIDTH, 8, width of one byte-enable column.
- COLUMNS, DATA_BITWIDTH/DATA_COLUMN_BITWIDTH, derived local parameter, not overridable.
- READ_FIRST, 0, same-port read-during-write: 0 = write-first (new data), 1 = read-first (old data).
- OUTPUT_REG, 0, 1 adds one output pipeline register per port.
- CLEAR_ON_RESET, 1, 1 zeroes the whole array after reset release.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- busy  out  1  high while the clear engine runs.
- a_write_enable  in  COLUMNS  per-column write enable, port A.
- a_address  in  ADDRESS_BITWIDTH  port A word address.
- a_data_in  in  DATA_BITWIDTH  port A write data.
- a_data_out  out  DATA_BITWIDTH  port A read data.
- b_write_enable  in  COLUMNS  per-column write enable, port B.
- b_address  in  ADDRESS_BITWIDTH  port B word address.
- b_data_in  in  DATA_BITWIDTH  port B write data.
- b_data_out  out  DATA_BITWIDTH  port B read data.
- collision  out  1  registered pulse: both ports wrote an overlapping column at the same address in the previous cycle.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - a_data_out, b_data_out, any pipeline registers and collision reset to 0.
  - busy resets to CLEAR_ON_RESET.
  - Array contents are not reset.
- Clear FSM, states IDLE and CLEAR:
  - After reset: state=CLEAR if CLEAR_ON_RESET, else IDLE; counter=0.
  - In CLEAR, one word per cycle: all columns of the word at counter are written 0, then counter increments.
  - On counter == depth-1, that word is written and the FSM moves to IDLE; busy falls the following cycle. busy is high for exactly 2**ADDRESS_BITWIDTH cycles after the first rising edge with rst_n=1.
  - While busy: all port writes are ignored, collision stays 0, and both data_out registers load 0.
  - Reset mid-clear restarts the clear from address 0.
- Write: on a rising edge with busy=0, each column i with x_write_enable[i]=1 writes x_data_in[column i] to data[x_address][column i]. Columns not enabled are unchanged.
- Read latency, address to data_out: 1 cycle with OUTPUT_REG=0, 2 cycles with OUTPUT_REG=1. Read is unconditional every cycle.
- Same-port read-during-write:
  - READ_FIRST=0: data_out shows merged new data (enabled columns new, others old).
  - READ_FIRST=1: data_out shows the old word.
- Cross-port read of an address written by the other port in the same cycle: always returns the old word. The new word is visible from the next read.
- Write collision (same address, overlapping enables):
  - Port A wins the overlapping columns.
  - Non-overlapping columns from each port are both written.
  - collision=1 in the following cycle. Same address with disjoint enables is not a collision.
- Address wrap: none; addresses are exactly ADDRESS_BITWIDTH wide.

Decomposition:
- Shared package bram_pkg:
  - clear-FSM state encoding (IDLE, CLEAR);
  - a function computing COLUMNS with a width-divisibility elaboration check.
- Sub-module bram_out_pipe: optional per-port output register (pass-through wire when OUTPUT_REG=0), with async reset; instantiated twice.

Test Plan (ADDRESS_BITWIDTH=4, 32-bit data, 8-bit columns):
- Release reset with CLEAR_ON_RESET=1 and array preloaded to 0xFFFFFFFF → busy high 16 cycles, then reads of addresses 0..15 on both ports return 0x00000000.
- Port A writes 0x11223344 to addr 3, we=4'b1111; then port A writes 0xAABBCCDD with we=4'b0101 → port B read of addr 3 returns 0x11BB33DD.
- READ_FIRST=0 vs 1: addr 5 holds 0x0; port A writes 0xDEADBEEF to addr 5 while reading addr 5 → a_data_out = 0xDEADBEEF (write-first) or 0x00000000 (read-first); b_data_out reading addr 5 in the same cycle = 0x00000000 in both modes.
- Same-cycle writes to addr 7: A data 0xAAAAAAAA we=4'b0011, B data 0xBBBBBBBB we=4'b0110 → addr 7 = 0x00BBAAAA (column 0 from A, column 1 A wins, column 2 from B, column 3 unchanged at 0), collision=1 for exactly one cycle. Repeat with B we=4'b1100 → addr 7 = 0xBBBBAAAA, collision=0.
- OUTPUT_REG=1: write 0x12345678 to addr 9, then present addr 9 on port B → b_data_out = 0x12345678 exactly 2 cycles after the address.
- Assert rst_n low at clear counter = 8, release → busy high a full 16 cycles again; writes attempted during busy do not land (readback of the target address after the clear returns 0).

Source files
------------

// File: rtl/bram_pkg.sv
// Shared definitions for the byte-enabled true-dual-port RAM family.
// Holds the clear-engine state encoding and the column-count helper.
package bram_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clear_state_t;

  // Returns 0 when the word does not split evenly into columns; the RAM rejects that at elaboration.
  function automatic int calc_columns(input int data_bw, input int col_bw);
    if (col_bw <= 0) return 0;
    if ((data_bw % col_bw) != 0) return 0;
    return data_bw / col_bw;
  endfunction

endpackage

// File: rtl/bram_out_pipe.sv
// Optional read-data output register for one RAM port.
// With ENABLE=0 the data passes straight through and clk/rst_n are unused.
module bram_out_pipe #(
  parameter int WIDTH  = 32,
  parameter bit ENABLE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (ENABLE) begin : g_reg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= '0;
        else        q <= d;
      end
    end else begin : g_wire
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign q = d;
    end
  endgenerate

endmodule

// File: rtl/bedpbram_tdp.sv
// True-dual-port RAM with per-column write enables, port-A-wins collision
// arbitration and a post-reset clear engine that zeroes one word per cycle.
//
// state | meaning
// IDLE  | normal operation, both ports read/write
// CLEAR | zeroing word clr_addr; port writes ignored, outputs forced to 0
module bedpbram_tdp
  import bram_pkg::*;
#(
  parameter int ADDRESS_BITWIDTH     = 16,
  parameter int DATA_BITWIDTH        = 32,
  parameter int DATA_COLUMN_BITWIDTH = 8,
  parameter int READ_FIRST           = 0,
  parameter int OUTPUT_REG           = 0,
  parameter int CLEAR_ON_RESET       = 1,
  localparam int COLUMNS = calc_columns(DATA_BITWIDTH, DATA_COLUMN_BITWIDTH)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  output logic                        busy,
  input  logic [COLUMNS-1:0]          a_write_enable,
  input  logic [ADDRESS_BITWIDTH-1:0] a_address,
  input  logic [DATA_BITWIDTH-1:0]    a_data_in,
  output logic [DATA_BITWIDTH-1:0]    a_data_out,
  input  logic [COLUMNS-1:0]          b_write_enable,
  input  logic [ADDRESS_BITWIDTH-1:0] b_address,
  input  logic [DATA_BITWIDTH-1:0]    b_data_in,
  output logic [DATA_BITWIDTH-1:0]    b_data_out,
  output logic                        collision
);

  localparam int DEPTH = 2 ** ADDRESS_BITWIDTH;
  localparam int CW    = DATA_COLUMN_BITWIDTH;

  generate
    if (COLUMNS == 0) begin : g_bad_width
      $error("DATA_BITWIDTH must be a non-zero multiple of DATA_COLUMN_BITWIDTH");
    end
  endgenerate

  logic [DATA_BITWIDTH-1:0]    mem [DEPTH];
  clear_state_t                state;
  logic [ADDRESS_BITWIDTH-1:0] clr_addr;
  logic [DATA_BITWIDTH-1:0]    a_mask, b_mask;
  logic [DATA_BITWIDTH-1:0]    a_rd, b_rd;
  logic [DATA_BITWIDTH-1:0]    a_q, b_q;

  assign busy = (state == CLEAR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      clr_addr <= '0;
    end else if (state == CLEAR) begin
      clr_addr <= clr_addr + 1'b1;
      if (clr_addr == '1) state <= IDLE;
    end
  end

  always_comb begin
    a_mask = '0;
    b_mask = '0;
    for (int i = 0; i < COLUMNS; i++) begin
      a_mask[i*CW +: CW] = {CW{a_write_enable[i]}};
      b_mask[i*CW +: CW] = {CW{b_write_enable[i]}};
    end
  end

  // Port A is written last so it overrides B on overlapping columns of the same word.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[clr_addr] <= '0;
    end else begin
      for (int i = 0; i < COLUMNS; i++) begin
        if (b_write_enable[i]) mem[b_address][i*CW +: CW] <= b_data_in[i*CW +: CW];
        if (a_write_enable[i]) mem[a_address][i*CW +: CW] <= a_data_in[i*CW +: CW];
      end
    end
  end

  // Cross-port reads always see the stored (old) word; only the own port's write is bypassed.
  always_comb begin
    a_rd = mem[a_address];
    b_rd = mem[b_address];
    if (READ_FIRST == 0) begin
      a_rd = (a_rd & ~a_mask) | (a_data_in & a_mask);
      b_rd = (b_rd & ~b_mask) | (b_data_in & b_mask);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      collision <= 1'b0;
    end else if (busy) begin
      a_q       <= '0;
      b_q       <= '0;
      collision <= 1'b0;
    end else begin
      a_q       <= a_rd;
      b_q       <= b_rd;
      collision <= (a_address == b_address) && (|(a_write_enable & b_write_enable));
    end
  end

  bram_out_pipe #(
    .WIDTH  (DATA_BITWIDTH),
    .ENABLE (OUTPUT_REG != 0)
  ) u_pipe_a (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (a_q),
    .q     (a_data_out)
  );

  bram_out_pipe #(
    .WIDTH  (DATA_BITWIDTH),
    .ENABLE (OUTPUT_REG != 0)
  ) u_pipe_b (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (b_q),
    .q     (b_data_out)
  );

endmodule
